split_fifo_drain_arb: RTL and testbench
=======================================

Name: split_fifo_drain_arb

Overview:
- Weighted round-robin read scheduler for the two halves of a sync split FIFO (half 1: 18-bit, half 2: 9-bit, same clock).
- Drives re1/re2 from the empty/empty-plus-one flags, captures the 1-cycle-latency read data and merges both streams onto one 18-bit valid/ready output tagged with its source.
- Sits between the split-FIFO wrapper and a single downstream consumer.

Parameters:
- WEIGHT1, 4, max consecutive grants to half 1 before yielding (1..15)
- WEIGHT2, 2, max consecutive grants to half 2 before yielding (1..15)
- CW, 4, width of the burst counter; must hold max(WEIGHT1, WEIGHT2)

Ports:
- clock0  in  1  sole clock; all logic on posedge
- rst_n  in  1  reset: synchronous, active-low
- en  in  1  1 = new reads may be issued; 0 = in-flight reads complete, no new re
- empty1  in  1  half-1 EMPTY
- epo1  in  1  half-1 empty-plus-one (exactly one entry)
- empty2  in  1  half-2 EMPTY
- epo2  in  1  half-2 empty-plus-one
- dout1  in  18  half-1 read data, valid the cycle after re1
- dout2  in  9  half-2 read data, valid the cycle after re2
- underrun1  in  1  half-1 UNDERRUN
- underrun2  in  1  half-2 UNDERRUN
- re1  out  1  read enable, half 1
- re2  out  1  read enable, half 2
- m_valid  out  1  output word valid
- m_data  out  18  output word; half-2 data zero-extended ({9'b0, dout2})
- m_src  out  1  0 = half 1, 1 = half 2
- m_ready  in  1  downstream accept
- err  out  1  sticky: underrun1 or underrun2 seen, or internal invariant broken

Behaviour:
Reset (rst_n = 0 at a clock edge):
- All outputs 0; FSM to S_ARB; ptr = 0 (half 1 preferred); burst counter 0; skid buffer empty; in-flight flag cleared.
- A read in flight when reset hits is discarded.
Read data path:
- re and in-flight are registered: re at cycle t puts data on dout at t+1; the block captures it into a 2-entry skid buffer at t+1.
Credit rule:
- re may assert only if (buffer occupancy + in-flight) < 2.
- Guarantees no capture is ever dropped, whatever m_ready does.
Underrun guard:
- Never assert re(x) while empty(x) = 1.
- After re(x) at cycle t with epo(x) = 1 sampled at t, re(x) is blocked at t+1 (flag lag bubble).
- Back-to-back reads from one half are allowed only when epo(x) = 0.
FSM states:
- S_ARB: pick a half whose read is legal, ptr half first, else the other half; go to S_BURST1 or S_BURST2; counter = 0. Stay in S_ARB if neither read is legal or en = 0.
- S_BURSTx: issue re(x) on every cycle it is legal and counter is incremented on each issue. Return to S_ARB with ptr = other half when counter reaches WEIGHTx, or when empty(x) = 1 and the other half is non-empty. Stay (stalled) if only credits block.
- en = 0 in any state: re deasserts the same cycle; FSM returns to S_ARB next cycle; ptr is kept.
Output:
- m_valid = buffer non-empty; head entry shown on m_data/m_src.
- Pop on m_valid & m_ready.
- Capture and pop in the same cycle are allowed.
- Output order equals issue order.
Throughput and latency:
- 1 word/clock when m_ready = 1 and depths ≥ 2.
- re to m_valid latency 1 cycle when the buffer is empty.
err:
- Set on underrun1 | underrun2, or on a capture with a full buffer; cleared only by reset.

Decomposition:
- Package split_fifo_arb_pkg holds: state enum (S_ARB, S_BURST1, S_BURST2), SRC_H1 = 1'b0, SRC_H2 = 1'b1, DATA_W = 18, H2_W = 9.
- Sub-module arb_skid_buf: 2-entry {src, data} buffer with push/pop/occupancy.

Test Plan:
- Write 50 random words to each half; en = 1, m_ready = 1 → output pattern is 4×H1, 2×H2 repeating. Each half's sequence matches its write order. H2 words arrive as {9'b0, din2}. err = 0.
- Only half 1 loaded with 3 words (empty2 = 1) → burst runs continuously with no yield. re1 pulses: 2 back-to-back, then a bubble when epo1 = 1, then the last read. 3 outputs; re1 never asserts while empty1.
- m_ready toggled 1-0-1-0 while both halves hold 20 words → occupancy + in-flight never exceeds 2. No word lost or duplicated. err = 0.
- en dropped mid-burst after 2 half-1 grants → re1 low the same cycle. The one in-flight word is still delivered. Re-raising en resumes from S_ARB with ptr = half 1.
- rst_n = 0 for one edge with 1 word buffered and 1 in flight → next cycle all outputs are 0 and buffer is empty. Resumes cleanly with ptr = half 1.
- underrun2 forced high for one cycle → err = 1 the following cycle and stays 1 until rst_n = 0.

Source files
------------

// File: rtl/split_fifo_drain_arb_pkg.sv
// Shared types and constants for the split-FIFO drain arbiter.
// Half 1 carries full-width words; half 2 words are zero-extended onto the same bus.
package split_fifo_arb_pkg;

   localparam int DATA_W = 18;
   localparam int H2_W   = 9;

   localparam logic SRC_H1 = 1'b0;
   localparam logic SRC_H2 = 1'b1;

   typedef enum logic [1:0] {
      S_ARB    = 2'd0,
      S_BURST1 = 2'd1,
      S_BURST2 = 2'd2
   } arbState_e;

   typedef struct packed {
      logic              src;
      logic [DATA_W-1:0] data;
   } skidEntry_t;

   function automatic logic [DATA_W-1:0] zeroExtH2(input logic [H2_W-1:0] d);
      return {{(DATA_W-H2_W){1'b0}}, d};
   endfunction

endpackage

// File: rtl/split_fifo_drain_arb_skid_buf.sv
// Two-entry {src, data} buffer holding captured read words until the consumer takes them.
// A push into a full buffer is accepted only when the head is popped in the same cycle.
module arb_skid_buf
   import split_fifo_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  skidEntry_t pushEntry_i,
   input  logic       pop_i,
   output skidEntry_t head_o,
   output logic [1:0] occupancy_o
);

   skidEntry_t mem_q [2];
   logic       wrPtr_q, wrPtr_d;
   logic       rdPtr_q, rdPtr_d;
   logic [1:0] count_q, count_d;
   logic       doPush, doPop;

   always_comb begin
      doPop   = pop_i && (count_q != 2'd0);
      doPush  = push_i && ((count_q != 2'd2) || doPop);
      wrPtr_d = doPush ? ~wrPtr_q : wrPtr_q;
      rdPtr_d = doPop ? ~rdPtr_q : rdPtr_q;
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + 2'd1;
      end else if (doPop && !doPush) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushEntry_i;
      end
   end

   assign head_o      = mem_q[rdPtr_q];
   assign occupancy_o = count_q;

endmodule

// File: rtl/split_fifo_drain_arb.sv
// Weighted round-robin drain of a split FIFO (18-bit and 9-bit halves) onto one
// valid/ready stream tagged with its source half, output order equal to issue order.
module split_fifo_drain_arb
   import split_fifo_arb_pkg::*;
#(
   parameter int WEIGHT1 = 4,
   parameter int WEIGHT2 = 2,
   parameter int CW      = 4
) (
   input  logic              clock0,
   input  logic              rst_n,
   input  logic              en,
   input  logic              empty1,
   input  logic              epo1,
   input  logic              empty2,
   input  logic              epo2,
   input  logic [DATA_W-1:0] dout1,
   input  logic [H2_W-1:0]   dout2,
   input  logic              underrun1,
   input  logic              underrun2,
   output logic              re1,
   output logic              re2,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_src,
   input  logic              m_ready,
   output logic              err
);

   localparam logic [CW-1:0] W1 = CW'(WEIGHT1);
   localparam logic [CW-1:0] W2 = CW'(WEIGHT2);

   arbState_e     state_q, state_d;
   logic          ptr_q, ptr_d;
   logic [CW-1:0] burstCnt_q, burstCnt_d;

   logic inFlight_q, inFlightSrc_q;
   logic lastRe1_q, lastEpo1_q, lastRe2_q, lastEpo2_q;
   logic err_q;

   skidEntry_t bufHead, captureEntry, headSel;
   logic [1:0] occupancy;
   logic [2:0] outstanding;
   logic       creditOk, legal1, legal2;
   logic       bufNonEmpty, outPop, bufPush, bufPop, captureFull;

   // A read may issue only with a free credit, a non-empty half, and not right after
   // a read that may have taken that half's last word (flags can lag by a cycle).
   assign outstanding = {1'b0, occupancy} + {2'b00, inFlight_q};
   assign creditOk    = outstanding < 3'd2;
   assign legal1 = rst_n && en && creditOk && !empty1 && !(lastRe1_q && (lastEpo1_q || epo1));
   assign legal2 = rst_n && en && creditOk && !empty2 && !(lastRe2_q && (lastEpo2_q || epo2));

   always_ff @(posedge clock0) begin
      if (!rst_n) begin
         state_q    <= S_ARB;
         ptr_q      <= SRC_H1;
         burstCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         burstCnt_q <= burstCnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      burstCnt_d = burstCnt_q;
      case (state_q)
         S_ARB: begin
            burstCnt_d = '0;
            if (legal1 && (ptr_q == SRC_H1 || !legal2)) begin
               state_d = S_BURST1;
            end else if (legal2) begin
               state_d = S_BURST2;
            end
         end
         S_BURST1: begin
            if (!en) begin
               state_d = S_ARB;
            end else begin
               if (re1) begin
                  burstCnt_d = burstCnt_q + 1'b1;
               end
               if (burstCnt_d == W1 || (empty1 && !empty2)) begin
                  state_d = S_ARB;
                  ptr_d   = SRC_H2;
               end
            end
         end
         S_BURST2: begin
            if (!en) begin
               state_d = S_ARB;
            end else begin
               if (re2) begin
                  burstCnt_d = burstCnt_q + 1'b1;
               end
               if (burstCnt_d == W2 || (empty2 && !empty1)) begin
                  state_d = S_ARB;
                  ptr_d   = SRC_H1;
               end
            end
         end
         default: state_d = S_ARB;
      endcase
   end

   always_comb begin
      re1 = (state_q == S_BURST1) && legal1;
      re2 = (state_q == S_BURST2) && legal2;
   end

   // The word arriving this cycle bypasses the buffer when the buffer is empty,
   // giving one cycle from re to m_valid and full rate without extra credits.
   always_comb begin
      captureEntry.src  = inFlightSrc_q;
      captureEntry.data = (inFlightSrc_q == SRC_H2) ? zeroExtH2(dout2) : dout1;
      bufNonEmpty       = occupancy != 2'd0;
      headSel           = bufNonEmpty ? bufHead : captureEntry;
      m_valid           = bufNonEmpty || inFlight_q;
      m_data            = m_valid ? headSel.data : '0;
      m_src             = m_valid ? headSel.src : 1'b0;
      outPop            = m_valid && m_ready;
      bufPush           = inFlight_q && !(outPop && !bufNonEmpty);
      bufPop            = outPop && bufNonEmpty;
      captureFull       = inFlight_q && (occupancy == 2'd2);
   end

   arb_skid_buf u_skid (
      .clk_i      (clock0),
      .rst_ni     (rst_n),
      .push_i     (bufPush),
      .pushEntry_i(captureEntry),
      .pop_i      (bufPop),
      .head_o     (bufHead),
      .occupancy_o(occupancy)
   );

   always_ff @(posedge clock0) begin
      if (!rst_n) begin
         inFlight_q    <= 1'b0;
         inFlightSrc_q <= SRC_H1;
         lastRe1_q     <= 1'b0;
         lastEpo1_q    <= 1'b0;
         lastRe2_q     <= 1'b0;
         lastEpo2_q    <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         inFlight_q    <= re1 || re2;
         inFlightSrc_q <= re2 ? SRC_H2 : SRC_H1;
         lastRe1_q     <= re1;
         lastEpo1_q    <= epo1;
         lastRe2_q     <= re2;
         lastEpo2_q    <= epo2;
         err_q         <= err_q || underrun1 || underrun2 || captureFull;
      end
   end

   assign err = err_q;

endmodule

// File: tb/tb_split_fifo_drain_arb.sv
// Self-checking bench: queue-based FIFO halves, issue-order scoreboard, vector tables
// for the multi-cycle corner cases and randomized drains.
module tb_split_fifo_drain_arb;

   typedef struct packed {
      logic        src;
      logic [17:0] data;
   } word_t;

   typedef struct packed {
      logic rstN;
      logic en;
      logic ready;
      logic expRe1;
      logic expRe2;
      logic expValid;
      logic expZero;
   } vec_t;

   logic        clock0 = 1'b0;
   logic        rst_n, en, empty1, epo1, empty2, epo2, underrun1, underrun2, m_ready;
   logic [17:0] dout1;
   logic [8:0]  dout2;
   logic        re1, re2, m_valid, m_src, err;
   logic [17:0] m_data;

   logic [17:0] q1 [$];
   logic [8:0]  q2 [$];
   word_t       issued [$];
   logic        srcLog [$];
   int          outCount;
   int          assertCount = 0;
   int          failCount   = 0;

   logic        prevRe1, prevEpo1, prevRe2, prevEpo2, errExp;
   logic        sRe1, sRe2, sValid, sSrc, sErr, sRst, sReady, sUnder;
   logic [17:0] sData;

   vec_t vecs2 [7];
   vec_t vecs4 [7];
   vec_t vecs5 [6];

   always #5 clock0 = ~clock0;

   split_fifo_drain_arb #(.WEIGHT1(4), .WEIGHT2(2), .CW(4)) dut (
      .clock0   (clock0),
      .rst_n    (rst_n),
      .en       (en),
      .empty1   (empty1),
      .epo1     (epo1),
      .empty2   (empty2),
      .epo2     (epo2),
      .dout1    (dout1),
      .dout2    (dout2),
      .underrun1(underrun1),
      .underrun2(underrun2),
      .re1      (re1),
      .re2      (re2),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_src    (m_src),
      .m_ready  (m_ready),
      .err      (err)
   );

   function automatic vec_t mk(input logic r, input logic e, input logic rd, input logic x1,
                               input logic x2, input logic v, input logic z);
      vec_t t;
      t.rstN = r; t.en = e; t.ready = rd; t.expRe1 = x1; t.expRe2 = x2; t.expValid = v; t.expZero = z;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic updateFlags();
      empty1 = (q1.size() == 0);
      epo1   = (q1.size() == 1);
      empty2 = (q2.size() == 0);
      epo2   = (q2.size() == 1);
   endtask

   // One clock: sample and check at negedge, then apply FIFO/scoreboard effects just after posedge.
   task automatic step();
      word_t w;
      @(negedge clock0);
      sRe1 = re1; sRe2 = re2; sValid = m_valid; sData = m_data; sSrc = m_src; sErr = err;
      sRst = rst_n; sReady = m_ready; sUnder = underrun1 | underrun2;
      if (sRst) begin
         checkOutput("re1WhileEmpty", sRe1 & empty1, 0);
         checkOutput("re2WhileEmpty", sRe2 & empty2, 0);
         checkOutput("re1WithoutEn", sRe1 & ~en, 0);
         checkOutput("re2WithoutEn", sRe2 & ~en, 0);
         checkOutput("re1Bubble", sRe1 & prevRe1 & (prevEpo1 | epo1), 0);
         checkOutput("re2Bubble", sRe2 & prevRe2 & (prevEpo2 | epo2), 0);
         checkOutput("reBoth", sRe1 & sRe2, 0);
         checkOutput("outstandingLimit", issued.size() <= 2, 1);
         checkOutput("mValid", sValid, issued.size() != 0);
         if (sValid && issued.size() != 0) begin
            checkOutput("mData", sData, issued[0].data);
            checkOutput("mSrc", sSrc, issued[0].src);
         end
      end
      checkOutput("err", sErr, errExp);
      prevRe1  = sRst & sRe1;
      prevEpo1 = sRst & epo1;
      prevRe2  = sRst & sRe2;
      prevEpo2 = sRst & epo2;
      @(posedge clock0);
      #1;
      if (!sRst) begin
         issued.delete();
         errExp = 1'b0;
      end else begin
         if (sUnder) errExp = 1'b1;
         if (sValid && sReady && issued.size() != 0) begin
            srcLog.push_back(issued[0].src);
            issued.delete(0);
            outCount++;
         end
         if (sRe1 && q1.size() != 0) begin
            dout1 = q1.pop_front();
            w.src = 1'b0; w.data = dout1;
            issued.push_back(w);
         end
         if (sRe2 && q2.size() != 0) begin
            dout2 = q2.pop_front();
            w.src = 1'b1; w.data = {9'b0, dout2};
            issued.push_back(w);
         end
      end
      updateFlags();
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      rst_n   = v.rstN;
      en      = v.en;
      m_ready = v.ready;
      step();
      checkOutput({tag, ".re1"}, sRe1, v.expRe1);
      checkOutput({tag, ".re2"}, sRe2, v.expRe2);
      checkOutput({tag, ".mValid"}, sValid, v.expValid);
      if (v.expZero) begin
         checkOutput({tag, ".mDataZero"}, sData, 0);
         checkOutput({tag, ".mSrcZero"}, sSrc, 0);
         checkOutput({tag, ".errZero"}, sErr, 0);
      end
   endtask

   task automatic doReset();
      q1.delete();
      q2.delete();
      updateFlags();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic loadHalves(input int n1, input int n2);
      for (int i = 0; i < n1; i++) q1.push_back(18'($urandom()));
      for (int i = 0; i < n2; i++) q2.push_back(9'($urandom()));
      updateFlags();
   endtask

   // mode 0: en/ready high; 1: ready toggles; 2: random en and ready
   task automatic drain(input int maxCycles, input int mode, input string tag);
      int n = 0;
      while ((q1.size() + q2.size() + issued.size()) != 0 && n < maxCycles) begin
         en      = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
         step();
         n++;
      end
      checkOutput({tag, ".drained"}, q1.size() + q2.size() + issued.size(), 0);
      en      = 1'b1;
      m_ready = 1'b1;
   endtask

   initial begin
      vecs2[0] = mk(1, 1, 1, 0, 0, 0, 0);
      vecs2[1] = mk(1, 1, 1, 1, 0, 0, 0);
      vecs2[2] = mk(1, 1, 1, 1, 0, 1, 0);
      vecs2[3] = mk(1, 1, 1, 0, 0, 1, 0);
      vecs2[4] = mk(1, 1, 1, 1, 0, 0, 0);
      vecs2[5] = mk(1, 1, 1, 0, 0, 1, 0);
      vecs2[6] = mk(1, 1, 1, 0, 0, 0, 0);

      vecs4[0] = mk(1, 1, 1, 0, 0, 0, 0);
      vecs4[1] = mk(1, 1, 1, 1, 0, 0, 0);
      vecs4[2] = mk(1, 1, 1, 1, 0, 1, 0);
      vecs4[3] = mk(1, 0, 1, 0, 0, 1, 0);
      vecs4[4] = mk(1, 0, 1, 0, 0, 0, 0);
      vecs4[5] = mk(1, 1, 1, 0, 0, 0, 0);
      vecs4[6] = mk(1, 1, 1, 1, 0, 0, 0);

      vecs5[0] = mk(1, 1, 0, 0, 0, 0, 0);
      vecs5[1] = mk(1, 1, 0, 1, 0, 0, 0);
      vecs5[2] = mk(1, 1, 0, 1, 0, 1, 0);
      vecs5[3] = mk(0, 1, 0, 0, 0, 1, 0);
      vecs5[4] = mk(1, 1, 1, 0, 0, 0, 1);
      vecs5[5] = mk(1, 1, 1, 1, 0, 0, 0);

      rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; underrun1 = 1'b0; underrun2 = 1'b0;
      dout1 = '0; dout2 = '0;
      prevRe1 = 1'b0; prevEpo1 = 1'b0; prevRe2 = 1'b0; prevEpo2 = 1'b0;
      errExp = 1'b0; outCount = 0;
      updateFlags();
      @(posedge clock0);
      #1;

      $display("[TB] reset state");
      step();
      checkOutput("rst.re1", sRe1, 0);
      checkOutput("rst.re2", sRe2, 0);
      checkOutput("rst.mValid", sValid, 0);
      checkOutput("rst.mData", sData, 0);
      checkOutput("rst.mSrc", sSrc, 0);
      rst_n = 1'b1;

      $display("[TB] weighted round robin, 50 words per half");
      doReset();
      loadHalves(50, 50);
      en = 1'b1; m_ready = 1'b1;
      srcLog.delete(); outCount = 0;
      drain(400, 0, "wrr");
      checkOutput("wrr.count", outCount, 100);
      for (int i = 0; i < 36 && i < srcLog.size(); i++)
         checkOutput("wrr.pattern", srcLog[i], (i % 6) >= 4);

      $display("[TB] half 1 only, three words");
      doReset();
      loadHalves(3, 0);
      outCount = 0;
      for (int i = 0; i < 7; i++) applyStimulus(vecs2[i], "burst3");
      drain(20, 0, "burst3");
      checkOutput("burst3.count", outCount, 3);

      $display("[TB] m_ready toggling, 20 words per half");
      doReset();
      loadHalves(20, 20);
      outCount = 0;
      drain(400, 1, "toggle");
      checkOutput("toggle.count", outCount, 40);

      $display("[TB] en dropped mid-burst");
      doReset();
      loadHalves(10, 10);
      outCount = 0;
      for (int i = 0; i < 7; i++) applyStimulus(vecs4[i], "enDrop");
      drain(200, 0, "enDrop");
      checkOutput("enDrop.count", outCount, 20);

      $display("[TB] reset with buffered and in-flight words");
      doReset();
      loadHalves(10, 5);
      for (int i = 0; i < 6; i++) applyStimulus(vecs5[i], "midReset");
      drain(200, 0, "midReset");

      $display("[TB] underrun makes err sticky");
      en = 1'b1; m_ready = 1'b1;
      underrun2 = 1'b1;
      step();
      underrun2 = 1'b0;
      step();
      checkOutput("underrun.errSet", sErr, 1);
      for (int i = 0; i < 3; i++) step();
      checkOutput("underrun.errHeld", sErr, 1);
      doReset();
      step();
      checkOutput("underrun.errCleared", sErr, 0);

      $display("[TB] randomized drains");
      for (int r = 0; r < 6; r++) begin
         loadHalves($urandom_range(0, 25), $urandom_range(0, 25));
         drain(600, 2, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
